// File: rtl/pipe_stage.sv
// Valid/ready pipeline register carrying one ALU operation (aluop, alusel, operands, write-back target).
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready; default is a 1-entry stage.
module pipe_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 3,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_aluop,
  input  logic [SEL_W-1:0]  in_alusel,
  input  logic [DATA_W-1:0] in_reg0,
  input  logic [DATA_W-1:0] in_reg1,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_aluop,
  output logic [SEL_W-1:0]  out_alusel,
  output logic [DATA_W-1:0] out_reg0,
  output logic [DATA_W-1:0] out_reg1,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              out_we,
  output logic [1:0]        occupancy
);

  localparam int PW = OP_W + SEL_W + 2 * DATA_W + ADDR_W + 1;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl_q, out_pl_d;
  logic          out_v_q, out_v_d;
  logic [1:0]    occ_q, occ_d;
  logic          accept;

  assign in_pl  = {in_aluop, in_alusel, in_reg0, in_reg1, in_waddr, in_we};
  assign accept = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic          skid_v_q, skid_v_d;
  logic          in_ready_q;

  // in_ready_q mirrors an empty skid slot, so accept never coincides with a full skid.
  assign in_ready = in_ready_q;

  always_comb begin
    out_pl_d  = out_pl_q;
    out_v_d   = out_v_q;
    skid_pl_d = skid_pl_q;
    skid_v_d  = skid_v_q;
    if (flush) begin
      out_pl_d  = '0;
      out_v_d   = 1'b0;
      skid_pl_d = '0;
      skid_v_d  = 1'b0;
    end else if (!out_v_q || out_ready) begin
      if (skid_v_q) begin
        out_pl_d  = skid_pl_q;
        out_v_d   = 1'b1;
        skid_pl_d = '0;
        skid_v_d  = 1'b0;
      end else if (accept) begin
        out_pl_d = in_pl;
        out_v_d  = 1'b1;
      end else begin
        out_pl_d = '0;
        out_v_d  = 1'b0;
      end
    end else if (accept) begin
      skid_pl_d = in_pl;
      skid_v_d  = 1'b1;
    end
    occ_d = {1'b0, out_v_d} + {1'b0, skid_v_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pl_q   <= '0;
      out_v_q    <= 1'b0;
      skid_pl_q  <= '0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      out_pl_q   <= out_pl_d;
      out_v_q    <= out_v_d;
      skid_pl_q  <= skid_pl_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= !skid_v_d;
      occ_q      <= occ_d;
    end
  end
`else
  assign in_ready = out_ready | ~out_v_q;

  always_comb begin
    out_pl_d = out_pl_q;
    out_v_d  = out_v_q;
    if (flush) begin
      out_pl_d = '0;
      out_v_d  = 1'b0;
    end else if (accept) begin
      out_pl_d = in_pl;
      out_v_d  = 1'b1;
    end else if (out_v_q && out_ready) begin
      out_pl_d = '0;
      out_v_d  = 1'b0;
    end
    occ_d = {1'b0, out_v_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pl_q <= '0;
      out_v_q  <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      out_pl_q <= out_pl_d;
      out_v_q  <= out_v_d;
      occ_q    <= occ_d;
    end
  end
`endif

  // Payload is forced to zero whenever the output slot is empty, so a bubble never writes back.
  assign {out_aluop, out_alusel, out_reg0, out_reg1, out_waddr, out_we} =
         out_v_q ? out_pl_q : '0;
  assign out_valid = out_v_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed literal checks plus a randomized run against a queue model.
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_aluop = '0;
  logic [2:0]  in_alusel = '0;
  logic [15:0] in_reg0 = '0;
  logic [15:0] in_reg1 = '0;
  logic [3:0]  in_waddr = '0;
  logic        in_we = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_aluop;
  logic [2:0]  out_alusel;
  logic [15:0] out_reg0;
  logic [15:0] out_reg1;
  logic [3:0]  out_waddr;
  logic        out_we;
  logic [1:0]  occupancy;

  int tests = 0;
  int fails = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [2:0]  aluop;
    logic [2:0]  alusel;
    logic [15:0] reg0;
    logic [15:0] reg1;
    logic [3:0]  waddr;
    logic        we;
  } pl_t;

  pl_t model_q[$];

  pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_alusel(in_alusel), .in_reg0(in_reg0), .in_reg1(in_reg1),
    .in_waddr(in_waddr), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_alusel(out_alusel), .out_reg0(out_reg0), .out_reg1(out_reg1),
    .out_waddr(out_waddr), .out_we(out_we),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected upstream readiness from the model: skid build accepts while fewer than 2 are held,
  // single-entry build accepts when empty or when the held word leaves this cycle.
  function automatic logic exp_in_ready();
    if (CAP == 2) return (model_q.size() < 2);
    return (model_q.size() == 0) || out_ready;
  endfunction

  // Behavioural model: a bounded FIFO, pop before push on each edge, flush and reset empty it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
    end else begin
      logic tin, tout;
      pl_t w;
      tin  = in_valid && exp_in_ready();
      tout = (model_q.size() > 0) && out_ready;
      w    = '{in_aluop, in_alusel, in_reg0, in_reg1, in_waddr, in_we};
      if (flush) begin
        model_q.delete();
      end else begin
        if (tout) void'(model_q.pop_front());
        if (tin) model_q.push_back(w);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pl_t e;
      e = (model_q.size() > 0) ? model_q[0] : '0;
      check("cmp_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      check("cmp_occupancy", 64'(occupancy), 64'(model_q.size()));
      check("cmp_in_ready",  64'(in_ready),  64'(exp_in_ready()));
      check("cmp_aluop",     64'(out_aluop), 64'(e.aluop));
      check("cmp_alusel",    64'(out_alusel), 64'(e.alusel));
      check("cmp_reg0",      64'(out_reg0),  64'(e.reg0));
      check("cmp_reg1",      64'(out_reg1),  64'(e.reg1));
      check("cmp_waddr",     64'(out_waddr), 64'(e.waddr));
      check("cmp_we",        64'(out_we),    64'(e.we));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a valid word offered.
    in_valid = 1'b1;
    in_reg0  = 16'h1234;
    in_we    = 1'b1;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_we",    64'(out_we),    64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_reg0",  64'(out_reg0),  64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..8 with the sink always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_we     = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_reg0 = 16'(i);
      step();
      check("stream_reg0", 64'(out_reg0), 64'(i));
      check("stream_occ",  64'(occupancy), 64'd1);
      check("stream_we",   64'(out_we), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_occ", 64'(occupancy), 64'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure into the skid slot.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_reg0   = 16'h00A1;
    step();
    check("bp_occ_a", 64'(occupancy), 64'd1);
    in_reg0 = 16'h00B2;
    step();
    check("bp_occ_ab", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_reg0 = 16'h00C3;
    step();
    check("bp_occ_hold", 64'(occupancy), 64'd2);
    check("bp_head_a",   64'(out_reg0), 64'h00A1);
    out_ready = 1'b1;
    step();
    check("bp_head_b", 64'(out_reg0), 64'h00B2);
    step();
    check("bp_head_c", 64'(out_reg0), 64'h00C3);
    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid), 64'd0);
`else
    // Combinational in_ready follows out_ready while a word is held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_reg0   = 16'h00A1;
    step();
    in_valid = 1'b0;
    check("nsk_valid",     64'(out_valid), 64'd1);
    check("nsk_rdy_low",   64'(in_ready),  64'd0);
    out_ready = 1'b1;
    #1;
    check("nsk_rdy_high",  64'(in_ready),  64'd1);
    step();
    check("nsk_empty", 64'(out_valid), 64'd0);
`endif

    // Flush from a full stage with a word offered at the same edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      in_reg0 = 16'h0050 + 16'(i);
      step();
    end
    check("fl_full_occ", 64'(occupancy), 64'(CAP));
    flush   = 1'b1;
    in_reg0 = 16'hFFFF;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_we",    64'(out_we),    64'd0);
    check("fl_occ",       64'(occupancy), 64'd0);
    out_ready = 1'b1;
    step();
    check("fl_no_ffff", 64'(out_valid), 64'd0);

    // Bubble never writes back.
    in_valid = 1'b0;
    in_we    = 1'b1;
    in_waddr = 4'd7;
    step();
    check("bub_valid", 64'(out_valid), 64'd0);
    check("bub_we",    64'(out_we),    64'd0);
    check("bub_waddr", 64'(out_waddr), 64'd0);

    // Randomized run with occasional flush and one asynchronous reset mid-stream.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 49) == 0;
      in_aluop  = 3'($urandom);
      in_alusel = 3'($urandom);
      in_reg0   = 16'($urandom);
      in_reg1   = 16'($urandom);
      in_waddr  = 4'($urandom);
      in_we     = 1'($urandom);
      if (c == 1500) begin
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_occ",   64'(occupancy), 64'd0);
        check("arst_reg0",  64'(out_reg0),  64'd0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand width (reg0/reg1).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning write-back register address width.
REQ-003 SHALL have parameter OP_W, default 3, meaning aluop width; parameter SEL_W, default 3, meaning alusel width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-008 SHALL have inputs in_aluop OP_W, in_alusel SEL_W, in_reg0 DATA_W, in_reg1 DATA_W, in_waddr ADDR_W and in_we 1, the upstream payload.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the downstream handshake.
REQ-010 SHALL have outputs out_aluop, out_alusel, out_reg0, out_reg1, out_waddr and out_we, each the same width as its in_ counterpart.
REQ-011 SHALL have port occupancy  output  2  number of entries held (0..2).

Function
REQ-012 Transfer in SHALL occur on a rising edge where in_valid & in_ready; transfer out SHALL occur on a rising edge where out_valid & out_ready.
REQ-013 Latency SHALL be 1 cycle: a word accepted at edge N is presented on out_* from edge N with out_valid=1.
REQ-014 Ordering SHALL be strict FIFO; no word is dropped or duplicated except by flush or reset.
REQ-015 out_we SHALL equal stored we AND out_valid; a bubble never writes back.
REQ-016 When out_valid=0, out_aluop, out_alusel, out_reg0, out_reg1 and out_waddr SHALL hold zero.
REQ-017 out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 Flush SHALL take priority: on the edge it is sampled, all entries clear, occupancy=0, out_valid=0, and a simultaneous in_valid word is dropped.
REQ-019 Simultaneous transfer in and out SHALL leave occupancy unchanged.
REQ-020 occupancy SHALL be registered and equal the number of valid entries.

Reset
REQ-021 While rst=0: out_valid=0, out_we=0, all out_* payload=0, occupancy=0, all internal entries invalid; effect immediate, independent of clk.
REQ-022 in_ready SHALL be 1 in the first cycle after rst deasserts in both configurations.
REQ-023 Reset mid-transfer SHALL discard all held words; no partial word may appear after release.

Configuration
REQ-024 Macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-025 With PIPE_STAGE_SKID_EN defined: 2 entries (output + skid); in_ready SHALL be a register equal to NOT skid-entry-valid, with no combinational path from out_ready to in_ready; full throughput of one word per cycle with out_ready=1; occupancy ranges 0..2.
REQ-026 Without PIPE_STAGE_SKID_EN: 1 entry; in_ready SHALL equal out_ready OR NOT out_valid (combinational); occupancy ranges 0..1; all other requirements unchanged.

Verification
REQ-027 Reset: hold rst=0 with in_valid=1, in_reg0=16'h1234 -> out_valid=0, out_we=0, occupancy=0; after release in_ready=1.
REQ-028 Streaming: 8 words reg0=1..8, in_we=1, out_ready=1 -> out_reg0 shows 1..8 on consecutive cycles, each 1 cycle after acceptance, occupancy=1 throughout.
REQ-029 Backpressure (SKID_EN): drive words A=16'h00A1, B=16'h00B2, C=16'h00C3, out_ready=0 -> occupancy reaches 2, in_ready=0 one cycle later, C held upstream; out_ready=1 -> A, B, C delivered in order, none lost.
REQ-030 Flush: occupancy=2, pulse flush with in_valid=1 (reg0=16'hFFFF) -> next cycle out_valid=0, out_we=0, occupancy=0, 16'hFFFF never appears.
REQ-031 Bubble: in_valid=0 with in_we=1, in_waddr=4'd7 -> out_valid=0, out_we=0, out_waddr=0.
REQ-032 Non-SKID build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle.
